// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag and state types shared by the pipelined ALU
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_SLL   = 4'd2,
      OP_SRL   = 4'd3,
      OP_AND   = 4'd4,
      OP_OR    = 4'd5,
      OP_XOR   = 4'd6,
      OP_EQ    = 4'd7,
      OP_SRA   = 4'd8,
      OP_SLT   = 4'd9,
      OP_SLTU  = 4'd10,
      OP_MUL   = 4'd11,
      OP_RSV12 = 4'd12,
      OP_RSV13 = 4'd13,
      OP_RSV14 = 4'd14,
      OP_RSV15 = 4'd15
   } alu_op_e;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
      logic err;
   } alu_flags_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add unsigned multiplier, one bit of b per cycle
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] ma_q, ma_d, acc_q, acc_d;
   logic [WIDTH-1:0]   mb_q, mb_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;

   // done_o marks the cycle whose iteration is the last one
   assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
   assign busy_o    = busy_q;
   assign product_o = acc_q;

   always_comb begin
      ma_d   = ma_q;
      mb_d   = mb_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start_i) begin
         ma_d   = {{WIDTH{1'b0}}, a_i};
         mb_d   = b_i;
         acc_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (mb_q[0]) begin
            acc_d = acc_q + ma_q;
         end
         ma_d  = ma_q << 1;
         mb_d  = mb_q >> 1;
         cnt_d = cnt_q + CW'(1);
         if (done_o) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ma_q   <= '0;
         mb_q   <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         ma_q   <= ma_d;
         mb_q   <= mb_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshakes and a multi-cycle multiply
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [3:0]       op_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] alu_o,
   output logic             zero_o,
   output logic             neg_o,
   output logic             carry_o,
   output logic             ovf_o,
   output logic             err_o
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_e         state_q, state_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   alu_q, alu_d;
   alu_flags_t         flags_q, flags_d;

   alu_op_e            op;
   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   res;
   alu_flags_t         res_fl;
   logic               accept;
   logic               mul_start, mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   assign op         = alu_op_e'(op_i);
   assign shamt      = b_i[SHW-1:0];
   assign in_ready_o = (state_q == IDLE) && (!out_valid_q || out_ready_i);
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      sum    = {1'b0, a_i} + {1'b0, b_i};
      res    = '0;
      res_fl = '0;
      case (op)
         OP_ADD: begin
            res          = sum[WIDTH-1:0];
            res_fl.carry = sum[WIDTH];
            res_fl.ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SUB: begin
            res          = a_i - b_i;
            res_fl.carry = (a_i < b_i);
            res_fl.ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SLL:  res    = a_i << shamt;
         OP_SRL:  res    = a_i >> shamt;
         OP_SRA:  res    = $unsigned($signed(a_i) >>> shamt);
         OP_AND:  res    = a_i & b_i;
         OP_OR:   res    = a_i | b_i;
         OP_XOR:  res    = a_i ^ b_i;
         OP_EQ:   res[0] = (a_i == b_i);
         OP_SLT:  res[0] = ($signed(a_i) < $signed(b_i));
         OP_SLTU: res[0] = (a_i < b_i);
         OP_MUL:  res    = '0;
         default: res_fl.err = 1'b1;
      endcase
      res_fl.zero = (res == '0);
      res_fl.neg  = res[WIDTH-1];
   end

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst       (reset),
      .start_i   (mul_start),
      .a_i       (a_i),
      .b_i       (b_i),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      alu_d       = alu_q;
      flags_d     = flags_q;
      mul_start   = 1'b0;
      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (op == OP_MUL) begin
                  mul_start = 1'b1;
                  state_d   = MUL;
               end else begin
                  alu_d       = res;
                  flags_d     = res_fl;
                  out_valid_d = 1'b1;
               end
            end
         end
         MUL: begin
            if (mul_busy && mul_done) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // product waits here until the output register is free
            if (!out_valid_q || out_ready_i) begin
               alu_d         = mul_prod[WIDTH-1:0];
               flags_d       = '0;
               flags_d.zero  = (mul_prod[WIDTH-1:0] == '0);
               flags_d.neg   = mul_prod[WIDTH-1];
               flags_d.ovf   = |mul_prod[2*WIDTH-1:WIDTH];
               out_valid_d   = 1'b1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         alu_q       <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         alu_q       <= alu_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign alu_o       = alu_q;
   assign zero_o      = flags_q.zero;
   assign neg_o       = flags_q.neg;
   assign carry_o     = flags_q.carry;
   assign ovf_o       = flags_q.ovf;
   assign err_o       = flags_q.err;

endmodule
